// File: rtl/game_select_menu_pkg.sv
// Shared menu definitions: mode codes, page encoding and level limits.
// Used by game_select_menu and kept in step with the game controller.
package game_select_menu_pkg;

    localparam logic       LIMITED   = 1'b0;
    localparam logic       FREE      = 1'b1;
    localparam logic [1:0] MAX_LEVEL = 2'd3;

    typedef enum logic [1:0] {
        PG_MODE  = 2'd0,
        PG_LEVEL = 2'd1,
        PG_PLAY  = 2'd2
    } page_e;

endpackage

// File: rtl/game_select_menu_btn.sv
// Button front end: 2-flop synchronizer, rising-edge detector and an optional
// hold-to-repeat counter. Produces one registered step pulse per press/repeat.
module btn_repeat #(
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step
);

    // Reloading to DELAY-PERIOD+1 makes every later expiry land PERIOD cycles apart.
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic             sync1_q, sync2_q, prev_q;
    logic             step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             repHit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            step_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        repHit = 1'b0;
        cnt_d  = '0;
        if (REPEAT_EN && sync2_q) begin
            if (cnt_q == DELAY_C) begin
                repHit = 1'b1;
                cnt_d  = RELOAD_C;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        step_d = (sync2_q & ~prev_q) | repHit;
    end

    assign step = step_q;

endmodule

// File: rtl/game_select_menu.sv
// Front-panel menu controller: page FSM over MODE/LEVEL/PLAY, pending and
// committed configuration, and the selecting/start handshake to the game.
module game_select_menu
    import game_select_menu_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25,
    parameter int NUM_LEVELS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    input  logic       btn_back,
    input  logic       game_done,
    output logic       selecting,
    output logic       mode,
    output logic [1:0] level,
    output logic [1:0] page,
    output logic       cur_mode,
    output logic [1:0] cur_level,
    output logic       start_pulse
);

    localparam logic [1:0] TOP_LEVEL = (NUM_LEVELS > 4) ? MAX_LEVEL : 2'(NUM_LEVELS - 1);

    logic  stepUp, stepDown, stepOk, stepBack;
    logic  goUp, goDown;

    page_e      page_q, page_d;
    logic       selecting_q, selecting_d;
    logic       mode_q, mode_d;
    logic [1:0] level_q, level_d;
    logic       curMode_q, curMode_d;
    logic [1:0] curLevel_q, curLevel_d;
    logic       startPulse_q, startPulse_d;

    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W))
        u_btnUp   (.clk(clk), .rst(rst), .btn(btn_up),   .step(stepUp));
    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W))
        u_btnDown (.clk(clk), .rst(rst), .btn(btn_down), .step(stepDown));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W))
        u_btnOk   (.clk(clk), .rst(rst), .btn(btn_ok),   .step(stepOk));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W))
        u_btnBack (.clk(clk), .rst(rst), .btn(btn_back), .step(stepBack));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_q       <= PG_MODE;
            selecting_q  <= 1'b1;
            mode_q       <= FREE;
            level_q      <= 2'd0;
            curMode_q    <= FREE;
            curLevel_q   <= 2'd0;
            startPulse_q <= 1'b0;
        end else begin
            page_q       <= page_d;
            selecting_q  <= selecting_d;
            mode_q       <= mode_d;
            level_q      <= level_d;
            curMode_q    <= curMode_d;
            curLevel_q   <= curLevel_d;
            startPulse_q <= startPulse_d;
        end
    end

    // Opposing up/down steps in one cycle cancel; back always outranks ok.
    assign goUp   = stepUp & ~stepDown;
    assign goDown = stepDown & ~stepUp;

    always_comb begin
        page_d       = page_q;
        selecting_d  = selecting_q;
        mode_d       = mode_q;
        level_d      = level_q;
        curMode_d    = curMode_q;
        curLevel_d   = curLevel_q;
        startPulse_d = 1'b0;
        case (page_q)
            PG_MODE: begin
                if (stepBack) begin
                    page_d = PG_MODE;
                end else if (stepOk) begin
                    page_d = PG_LEVEL;
                end else if (goUp || goDown) begin
                    curMode_d = ~curMode_q;
                end
            end
            PG_LEVEL: begin
                if (stepBack) begin
                    page_d     = PG_MODE;
                    curMode_d  = mode_q;
                    curLevel_d = level_q;
                end else if (stepOk) begin
                    page_d       = PG_PLAY;
                    mode_d       = curMode_q;
                    level_d      = curLevel_q;
                    selecting_d  = 1'b0;
                    startPulse_d = 1'b1;
                end else if (goUp && curLevel_q != TOP_LEVEL) begin
                    curLevel_d = curLevel_q + 2'd1;
                end else if (goDown && curLevel_q != 2'd0) begin
                    curLevel_d = curLevel_q - 2'd1;
                end
            end
            PG_PLAY: begin
                if (stepBack || (stepOk && game_done)) begin
                    page_d      = PG_MODE;
                    selecting_d = 1'b1;
                    curMode_d   = mode_q;
                    curLevel_d  = level_q;
                end
            end
            default: begin
                page_d      = PG_MODE;
                selecting_d = 1'b1;
            end
        endcase
    end

    assign selecting   = selecting_q;
    assign mode        = mode_q;
    assign level       = level_q;
    assign page        = page_q;
    assign cur_mode    = curMode_q;
    assign cur_level   = curLevel_q;
    assign start_pulse = startPulse_q;

endmodule

// File: tb/tb_game_select_menu.sv
// Directed bench for game_select_menu with short repeat timing
// (delay 8, period 4) and hand-computed expectations.
module tb_game_select_menu;
    import game_select_menu_pkg::*;

    logic       clk;
    logic       rst;
    logic       btnUp, btnDown, btnOk, btnBack, gameDone;
    logic       selecting, mode, curMode, startPulse;
    logic [1:0] level, page, curLevel;

    int checks = 0;
    int errors = 0;

    game_select_menu #(
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .CNT_W(4), .NUM_LEVELS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btnUp), .btn_down(btnDown), .btn_ok(btnOk), .btn_back(btnBack),
        .game_done(gameDone),
        .selecting(selecting), .mode(mode), .level(level), .page(page),
        .cur_mode(curMode), .cur_level(curLevel), .start_pulse(startPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle press of the selected buttons, then wait for the effect to land.
    task automatic applyStimulus(input logic u, input logic d, input logic o, input logic b);
        @(negedge clk);
        btnUp = u; btnDown = d; btnOk = o; btnBack = b;
        @(negedge clk);
        btnUp = 1'b0; btnDown = 1'b0; btnOk = 1'b0; btnBack = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        btnUp = 1'b0; btnDown = 1'b0; btnOk = 1'b0; btnBack = 1'b0; gameDone = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_selecting", 4'(selecting), 4'd1);
        checkOutput("rst_page", 4'(page), 4'(PG_MODE));
        checkOutput("rst_mode", 4'(mode), 4'(FREE));
        checkOutput("rst_level", 4'(level), 4'd0);
        checkOutput("rst_cur_mode", 4'(curMode), 4'(FREE));
        checkOutput("rst_cur_level", 4'(curLevel), 4'd0);
        checkOutput("rst_start", 4'(startPulse), 4'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Launch with defaults; commit lands on the 4th edge after ok is sampled
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_page_level", 4'(page), 4'(PG_LEVEL));
        @(negedge clk);
        btnOk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) btnOk = 1'b0;
            checkOutput($sformatf("t1_start_k%0d", k), 4'(startPulse), 4'(k == 4));
            checkOutput($sformatf("t1_selecting_k%0d", k), 4'(selecting), 4'(k < 4));
        end
        repeat (2) @(negedge clk);
        checkOutput("t1_page_play", 4'(page), 4'(PG_PLAY));
        checkOutput("t1_mode", 4'(mode), 4'(FREE));
        checkOutput("t1_level", 4'(level), 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_back_page", 4'(page), 4'(PG_MODE));
        checkOutput("t1_back_selecting", 4'(selecting), 4'd1);

        // Configure LIMITED, level saturates at 3
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_cur_mode", 4'(curMode), 4'(LIMITED));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_page_level", 4'(page), 4'(PG_LEVEL));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_lvl1", 4'(curLevel), 4'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_lvl3", 4'(curLevel), 4'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_lvl_sat", 4'(curLevel), 4'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_page_play", 4'(page), 4'(PG_PLAY));
        checkOutput("t2_mode", 4'(mode), 4'(LIMITED));
        checkOutput("t2_level", 4'(level), 4'd3);
        checkOutput("t2_selecting", 4'(selecting), 4'd0);

        // Back to menu reloads committed values, then into level page
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_reload_mode", 4'(curMode), 4'(LIMITED));
        checkOutput("t3_reload_level", 4'(curLevel), 4'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_page_level", 4'(page), 4'(PG_LEVEL));

        // Hold down: steps land after edges 4, 12, 16 (and 20, saturated)
        @(negedge clk);
        btnDown = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 3)  checkOutput("t3_hold_k3", 4'(curLevel), 4'd3);
            if (k == 4)  checkOutput("t3_hold_k4", 4'(curLevel), 4'd2);
            if (k == 11) checkOutput("t3_hold_k11", 4'(curLevel), 4'd2);
            if (k == 12) checkOutput("t3_hold_k12", 4'(curLevel), 4'd1);
            if (k == 15) checkOutput("t3_hold_k15", 4'(curLevel), 4'd1);
            if (k == 16) checkOutput("t3_hold_k16", 4'(curLevel), 4'd0);
            if (k == 20) checkOutput("t3_hold_k20", 4'(curLevel), 4'd0);
        end
        @(negedge clk);
        btnDown = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("t3_after_release", 4'(curLevel), 4'd0);

        // Simultaneous presses
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_up", 4'(curLevel), 4'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_updown", 4'(curLevel), 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_okback_page", 4'(page), 4'(PG_MODE));
        checkOutput("t4_okback_level", 4'(level), 4'd3);
        checkOutput("t4_okback_mode", 4'(mode), 4'(LIMITED));
        checkOutput("t4_okback_cur_level", 4'(curLevel), 4'd3);
        checkOutput("t4_okback_start", 4'(startPulse), 4'd0);

        // Return from play
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_mode", 4'(mode), 4'(FREE));
        checkOutput("t5_level", 4'(level), 4'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_play_up_ignored", 4'(curLevel), 4'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_ok_nodone_page", 4'(page), 4'(PG_PLAY));
        checkOutput("t5_ok_nodone_sel", 4'(selecting), 4'd0);
        gameDone = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        gameDone = 1'b0;
        checkOutput("t5_done_page", 4'(page), 4'(PG_MODE));
        checkOutput("t5_done_sel", 4'(selecting), 4'd1);
        checkOutput("t5_done_cur_mode", 4'(curMode), 4'(FREE));
        checkOutput("t5_done_cur_level", 4'(curLevel), 4'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_play2_mode", 4'(mode), 4'(LIMITED));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_back_page", 4'(page), 4'(PG_MODE));
        checkOutput("t5_back_sel", 4'(selecting), 4'd1);

        // Asynchronous reset during play
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_in_play", 4'(selecting), 4'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_sel", 4'(selecting), 4'd1);
        checkOutput("t6_rst_mode", 4'(mode), 4'(FREE));
        checkOutput("t6_rst_level", 4'(level), 4'd0);
        checkOutput("t6_rst_page", 4'(page), 4'(PG_MODE));
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t6_after_page", 4'(page), 4'(PG_MODE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_select_menu.md
# game_select_menu

Front-panel menu controller for the balance-board game. It turns four raw push-buttons into the configuration and sequencing signals consumed by the top-level game controller: `selecting`, the committed `mode`, and the committed `level`. It also exports the menu page and cursor values for the mask renderer. It sits between the board buttons and `top_control`, and is the only source of `selecting`.

## Interface
- `REPEAT_DELAY`, default 25000000: cycles a held up/down button must stay high before auto-repeat starts.
- `REPEAT_PERIOD`, default 5000000: cycles between auto-repeat steps.
- `CNT_W`, default 25: width of the repeat counter; must hold `REPEAT_DELAY`.
- `NUM_LEVELS`, default 4: number of levels, range 2..4.
- `clk  in  1`: system clock; the only clock.
- `rst  in  1`: asynchronous, active-low reset.
- `btn_up, btn_down, btn_ok, btn_back  in  1 each`: raw, debounced, asynchronous-to-clk buttons, active-high.
- `game_done  in  1`: high while the game controller is in its END state.
- `selecting  out  1`: high while the menu owns the game; low during play.
- `mode  out  1`: committed mode, `LIMITED` or `FREE` from head.v.
- `level  out  2`: committed level.
- `page  out  2`: current menu page (`PG_MODE`, `PG_LEVEL`, `PG_PLAY`), used for mask selection.
- `cur_mode  out  1`, `cur_level  out  2`: pending (uncommitted) menu values, for display.
- `start_pulse  out  1`: one-cycle strobe when a game is launched.

## Operation
- Buttons pass through a 2-flop synchronizer, then a rising-edge detector. Each press gives exactly one step pulse.
- Auto-repeat applies to up and down only:
  - While the synchronized button stays high, `repeat_cnt` counts.
  - At `REPEAT_DELAY` it emits a step and reloads to count `REPEAT_PERIOD`, emitting a step on each expiry.
  - Release clears the counter.
- Page FSM, encoded by `page`:
  - **PG_MODE:** up or down toggles `cur_mode`. ok goes to PG_LEVEL. back is ignored.
  - **PG_LEVEL:** up increments `cur_level` and down decrements it, both saturating at `0` and `NUM_LEVELS-1` with no wrap. back goes to PG_MODE. ok commits `mode<=cur_mode` and `level<=cur_level`, pulses `start_pulse`, drives `selecting<=0`, and goes to PG_PLAY.
  - **PG_PLAY:** up and down are ignored. back goes to PG_MODE with `selecting<=1`, aborting the game. ok while `game_done=1` also returns to PG_MODE with `selecting<=1`. ok while `game_done=0` is ignored.
  - On re-entry to PG_MODE, `cur_mode` and `cur_level` reload from the committed `mode` and `level`.
- Simultaneous events:
  - up and down in the same cycle: both ignored.
  - ok and back in the same cycle: back wins.
  - An auto-repeat step coinciding with a fresh edge counts as one step.
- `mode` and `level` change only at commit. They are stable for the entire PG_PLAY interval.

## Timing
- Reset values: `selecting=1`, `page=PG_MODE`, `mode=FREE`, `level=0`, `cur_mode=FREE`, `cur_level=0`, `start_pulse=0`, synchronizers and `repeat_cnt` at 0.
- Latency from a raw button rise to its effect:
  - Cycles 1–2: synchronizer.
  - Cycle 3: edge pulse.
  - The registered output updates on the 4th rising edge after the button is sampled high.
- On commit, `selecting` falls, and `start_pulse` is high for exactly that same one cycle.
- First auto-repeat step: `REPEAT_DELAY` cycles after the edge step. Following steps: every `REPEAT_PERIOD` cycles.
- Reset asserted mid-game forces `selecting` high immediately (asynchronous), with all values back to reset state.

## Structure
- head.v, shared with `top_control`, holds:
  - `LIMITED` and `FREE` mode codes.
  - `PG_MODE=2'd0`, `PG_LEVEL=2'd1`, `PG_PLAY=2'd2`.
  - `MAX_LEVEL`.
- One sub-module, `btn_repeat`, instantiated four times with repeat enabled only on up and down:
  - Contains the synchronizer, edge detector and optional repeat counter.
  - Parameters: `REPEAT_EN`, `REPEAT_DELAY`, `REPEAT_PERIOD`, `CNT_W`.
  - Output: `step`.
- The remainder, page FSM and value registers, lives in `game_select_menu`.

## Test plan
Run with `REPEAT_DELAY=8`, `REPEAT_PERIOD=4`, `CNT_W=4`, `NUM_LEVELS=4`.
1. **Reset, then launch:** release reset, pulse ok, pulse ok → `page` goes 0→1→2; on the second ok, `selecting` falls and `start_pulse` is high for 1 cycle with `mode=FREE`, `level=0`.
2. **Configure values:** in PG_MODE pulse up (`cur_mode=LIMITED`), ok, then up three times and up again → `cur_level=3` and stays 3 (saturation); ok → `mode=LIMITED`, `level=3`.
3. **Auto-repeat:** hold down in PG_LEVEL from `cur_level=3` for 20 cycles → steps at the edge, +8 and +12, giving `cur_level` 2, 1, 0; further steps hold at 0.
4. **Simultaneous presses:** up and down in the same cycle → no change; ok and back in the same cycle in PG_LEVEL → `page=PG_MODE`, no commit.
5. **Return from play:** in PG_PLAY press ok with `game_done=0` → ignored; with `game_done=1` → `selecting=1`, `page=PG_MODE`, `cur_*` reload from committed values; back during play → immediate return.
6. **Reset mid-game:** assert `rst` low asynchronously between clock edges during PG_PLAY → `selecting=1` and `mode=FREE` before the next edge.
